// File: rtl/uart_frame_rx_unit_pkg.sv
// Shared constants, state encodings and payload type for the UART frame receiver.
package uart_frame_rx_unit_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT  = 8'hAA;
  localparam int unsigned PAYLOAD_BYTES      = 8;
  localparam int unsigned OVERSAMPLE         = 16;
  localparam int unsigned SAMPLE_POINT       = 8;
  localparam int unsigned BITS_PER_BYTE_TIME = 10;

  typedef enum logic [1:0] {
    BYTE_IDLE,
    BYTE_START,
    BYTE_DATA,
    BYTE_STOP
  } byte_state_e;

  typedef enum logic [1:0] {
    FRM_HUNT,
    FRM_PAYLOAD,
    FRM_CHECK
  } frame_state_e;

  typedef struct packed {
    logic [31:0] word1;
    logic [31:0] word2;
  } frame_words_t;

  // Oversample divider: round(clk / (baud * 16)), never below 1
  function automatic int unsigned calc_div(int unsigned clk_hz, int unsigned baud);
    int unsigned den;
    int unsigned d;
    den = baud * OVERSAMPLE;
    d   = (clk_hz + den / 2) / den;
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// Byte receiver: input synchroniser, 16x oversample tick and start/data/stop FSM.
module uart_byte_rx
  import uart_frame_rx_unit_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_async,
  output logic       tick,
  output logic [7:0] byte_data,
  output logic       byte_done,
  output logic       byte_ferr
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] SAMPLE_IDX = OS_W'(SAMPLE_POINT - 1);

  logic [1:0]       sync_q;
  logic             rx_prev;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic [OS_W-1:0]  os_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
  byte_state_e      state;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rx_async};
      rx_prev <= rx_s;
    end
  end

  // Free-running oversample tick divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_W'(DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      tick    <= 1'b0;
    end
  end

  // Byte FSM: each bit sampled on the 8th tick of its bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BYTE_IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      byte_data <= '0;
      byte_done <= 1'b0;
      byte_ferr <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      byte_ferr <= 1'b0;
      case (state)
        BYTE_IDLE: begin
          if (rx_prev && !rx_s) begin
            state  <= BYTE_START;
            os_cnt <= '0;
          end
        end
        BYTE_START: begin
          if (tick) begin
            os_cnt <= os_cnt + OS_W'(1);
            if (os_cnt == SAMPLE_IDX) begin
              state   <= rx_s ? BYTE_IDLE : BYTE_DATA;
              bit_cnt <= '0;
            end
          end
        end
        BYTE_DATA: begin
          if (tick) begin
            os_cnt <= os_cnt + OS_W'(1);
            if (os_cnt == SAMPLE_IDX) begin
              shift_q <= {rx_s, shift_q[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= BYTE_STOP;
            end
          end
        end
        BYTE_STOP: begin
          if (tick) begin
            os_cnt <= os_cnt + OS_W'(1);
            if (os_cnt == SAMPLE_IDX) begin
              state <= BYTE_IDLE;
              if (rx_s) begin
                byte_done <= 1'b1;
                byte_data <= shift_q;
              end else begin
                byte_ferr <= 1'b1;
              end
            end
          end
        end
        default: state <= BYTE_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_rx_unit.sv
// UART command-frame receiver: sync hunt, 8-byte payload assembly, timeout and
// a one-entry valid/ready output buffer. Optional checksum byte is enabled by
// defining UART_FRAME_CHECKSUM_EN.
module uart_frame_rx_unit
  import uart_frame_rx_unit_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 50000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        uart_rx_in,
  output logic [31:0] rx_data1_out,
  output logic [31:0] rx_data2_out,
  output logic        rx_valid_out,
  input  logic        rx_ready_in,
  output logic        frame_err_out,
  output logic        overrun_out
);

  localparam int unsigned DIV      = calc_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned TO_TICKS = TIMEOUT_BYTES * BITS_PER_BYTE_TIME * OVERSAMPLE;
  localparam int unsigned TO_W     = $clog2(TO_TICKS + 1);
  localparam int unsigned IDX_W    = $clog2(PAYLOAD_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);

  logic             tick;
  logic [7:0]       byte_data;
  logic             byte_done;
  logic             byte_ferr;
  frame_state_e     state;
  logic [IDX_W-1:0] idx;
  logic [63:0]      asm_q;
  logic [TO_W-1:0]  to_cnt;
  logic             complete_c;
  frame_words_t     frame_c;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]       sum_q;
`endif

  uart_byte_rx #(.DIV(DIV)) u_byte_rx (
    .clk       (sys_clk),
    .rst_n     (reset_n),
    .rx_async  (uart_rx_in),
    .tick      (tick),
    .byte_data (byte_data),
    .byte_done (byte_done),
    .byte_ferr (byte_ferr)
  );

  // Frame completion strobe and the words it would deliver
  always_comb begin
    complete_c = 1'b0;
    frame_c    = frame_words_t'({asm_q[55:0], byte_data});
`ifdef UART_FRAME_CHECKSUM_EN
    if (byte_done && state == FRM_CHECK && byte_data == sum_q) begin
      complete_c = 1'b1;
      frame_c    = frame_words_t'(asm_q);
    end
`else
    if (byte_done && state == FRM_PAYLOAD && idx == IDX_LAST) complete_c = 1'b1;
`endif
  end

  // Frame FSM: sync hunt, payload collection, checksum and inter-byte timeout
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= FRM_HUNT;
      idx           <= '0;
      asm_q         <= '0;
      to_cnt        <= '0;
      frame_err_out <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      frame_err_out <= 1'b0;
      if (byte_ferr) begin
        frame_err_out <= 1'b1;
        state         <= FRM_HUNT;
        to_cnt        <= '0;
      end else if (byte_done) begin
        to_cnt <= '0;
        case (state)
          FRM_HUNT: begin
            if (byte_data == SYNC_BYTE) begin
              state <= FRM_PAYLOAD;
              idx   <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
              sum_q <= '0;
`endif
            end
          end
          FRM_PAYLOAD: begin
            asm_q <= {asm_q[55:0], byte_data};
            idx   <= idx + IDX_W'(1);
`ifdef UART_FRAME_CHECKSUM_EN
            sum_q <= sum_q + byte_data;
            if (idx == IDX_LAST) state <= FRM_CHECK;
`else
            if (idx == IDX_LAST) state <= FRM_HUNT;
`endif
          end
`ifdef UART_FRAME_CHECKSUM_EN
          FRM_CHECK: begin
            state <= FRM_HUNT;
            if (byte_data != sum_q) frame_err_out <= 1'b1;
          end
`endif
          default: state <= FRM_HUNT;
        endcase
      end else if (state != FRM_HUNT && tick) begin
        if (to_cnt == TO_W'(TO_TICKS - 1)) begin
          frame_err_out <= 1'b1;
          state         <= FRM_HUNT;
          to_cnt        <= '0;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
    end
  end

  // One-entry output buffer; a completion that finds it held is dropped
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data1_out <= '0;
      rx_data2_out <= '0;
      rx_valid_out <= 1'b0;
      overrun_out  <= 1'b0;
    end else begin
      overrun_out <= 1'b0;
      if (complete_c) begin
        if (rx_valid_out && !rx_ready_in) begin
          overrun_out <= 1'b1;
        end else begin
          rx_data1_out <= frame_c.word1;
          rx_data2_out <= frame_c.word2;
          rx_valid_out <= 1'b1;
        end
      end else if (rx_valid_out && rx_ready_in) begin
        rx_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx_unit.sv
// Testbench for uart_frame_rx_unit: serial frames driven bit by bit, received
// words compared against a scoreboard of the frames sent.
module tb_uart_frame_rx_unit;

  localparam int unsigned CLK_HZ  = 3200000;
  localparam int unsigned BAUD    = 100000;
  localparam int unsigned DIV_TB  = 2;
  localparam int unsigned BIT_CYC = DIV_TB * 16;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        uart_rx_in = 1'b1;
  logic [31:0] rx_data1_out;
  logic [31:0] rx_data2_out;
  logic        rx_valid_out;
  logic        rx_ready_in = 1'b0;
  logic        frame_err_out;
  logic        overrun_out;

  int checks = 0;
  int errors = 0;

  logic [63:0] got_q[$];
  int          err_cnt = 0;
  int          ovr_cnt = 0;
  int          vld_cyc = 0;
  int          hold_changes = 0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_data = '0;

  uart_frame_rx_unit #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .BAUD_RATE    (BAUD),
    .SYNC_BYTE    (8'hAA),
    .TIMEOUT_BYTES(4)
  ) dut (
    .sys_clk      (sys_clk),
    .reset_n      (reset_n),
    .uart_rx_in   (uart_rx_in),
    .rx_data1_out (rx_data1_out),
    .rx_data2_out (rx_data2_out),
    .rx_valid_out (rx_valid_out),
    .rx_ready_in  (rx_ready_in),
    .frame_err_out(frame_err_out),
    .overrun_out  (overrun_out)
  );

  always #5 sys_clk = ~sys_clk;

  // Output monitor: transfers, pulses and stability while held
  always @(negedge sys_clk) begin
    if (rx_valid_out) vld_cyc++;
    if (rx_valid_out && rx_ready_in) got_q.push_back({rx_data1_out, rx_data2_out});
    if (frame_err_out) err_cnt++;
    if (overrun_out) ovr_cnt++;
    if (rx_valid_out && prev_hold && {rx_data1_out, rx_data2_out} !== prev_data) hold_changes++;
    prev_hold = rx_valid_out && !rx_ready_in;
    prev_data = {rx_data1_out, rx_data2_out};
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge sys_clk);
    #1 rx_ready_in = r;
  endtask

  task automatic clear_mon();
    got_q.delete();
    err_cnt = 0;
    ovr_cnt = 0;
    vld_cyc = 0;
    hold_changes = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge sys_clk);
    uart_rx_in = 1'b0;
    idle(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      idle(BIT_CYC);
    end
    uart_rx_in = stop_bit;
    idle(BIT_CYC);
    uart_rx_in = 1'b1;
  endtask

`ifdef UART_FRAME_CHECKSUM_EN
  function automatic logic [7:0] sum8(input logic [63:0] p);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 8; i++) s = s + p[8*i +: 8];
    return s;
  endfunction
`endif

  task automatic send_frame(input logic [63:0] p);
    send_byte(8'hAA, 1'b1);
    for (int i = 7; i >= 0; i--) send_byte(p[8*i +: 8], 1'b1);
`ifdef UART_FRAME_CHECKSUM_EN
    send_byte(sum8(p), 1'b1);
`endif
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    idle(5);
    checks++; if (rx_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid_out); end
    checks++; if (rx_data1_out !== 32'h0) begin errors++; $display("FAIL reset_data1 got %h exp 0", rx_data1_out); end
    checks++; if (rx_data2_out !== 32'h0) begin errors++; $display("FAIL reset_data2 got %h exp 0", rx_data2_out); end
    checks++; if (frame_err_out !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", frame_err_out); end
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun_out); end
    reset_n = 1'b1;
    idle(10);
    checks++; if (rx_valid_out !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b exp 0", rx_valid_out); end
  endtask

  task automatic test_good_frame();
    set_ready(1'b1);
    clear_mon();
    send_frame(64'h123456789ABCDEF0);
    idle(2 * BIT_CYC);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL good_count got %0d exp 1", got_q.size()); end
    checks++; if (rx_data1_out !== 32'h12345678) begin errors++; $display("FAIL good_data1 got %h exp 12345678", rx_data1_out); end
    checks++; if (rx_data2_out !== 32'h9ABCDEF0) begin errors++; $display("FAIL good_data2 got %h exp 9abcdef0", rx_data2_out); end
    checks++; if (vld_cyc !== 1) begin errors++; $display("FAIL good_valid_cycles got %0d exp 1", vld_cyc); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL good_err got %0d exp 0", err_cnt); end
`ifndef UART_FRAME_CHECKSUM_EN
    send_byte(8'h38, 1'b1);
    idle(2 * BIT_CYC);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL trailing_count got %0d exp 1", got_q.size()); end
    checks++; if (rx_valid_out !== 1'b0) begin errors++; $display("FAIL trailing_valid got %b exp 0", rx_valid_out); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL trailing_err got %0d exp 0", err_cnt); end
`endif
  endtask

  task automatic test_random_frames();
    logic [63:0] exp_q[$];
    logic [63:0] p;
    clear_mon();
    for (int f = 0; f < 4; f++) begin
      p = rand64();
      if (f == 1) p[47:40] = 8'hAA;
      exp_q.push_back(p);
      send_frame(p);
    end
    idle(2 * BIT_CYC);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_frame%0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 64'h0, exp_q[i]);
      end
    end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL rand_err got %0d exp 0", err_cnt); end
  endtask

`ifdef UART_FRAME_CHECKSUM_EN
  task automatic test_bad_checksum();
    logic [63:0] p;
    p = 64'h123456789ABCDEF0;
    clear_mon();
    send_byte(8'hAA, 1'b1);
    for (int i = 7; i >= 0; i--) send_byte(p[8*i +: 8], 1'b1);
    send_byte(sum8(p) + 8'd1, 1'b1);
    idle(2 * BIT_CYC);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL badsum_count got %0d exp 0", got_q.size()); end
    checks++; if (vld_cyc !== 0) begin errors++; $display("FAIL badsum_valid got %0d exp 0", vld_cyc); end
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL badsum_err got %0d exp 1", err_cnt); end
    p = rand64();
    send_frame(p);
    idle(2 * BIT_CYC);
    checks++; if (got_q.size() !== 1 || got_q[0] !== p) begin errors++; $display("FAIL badsum_recover got %0d frames exp 1 frame %h", got_q.size(), p); end
  endtask
`endif

  task automatic test_glitch();
    logic [63:0] p;
    clear_mon();
    @(negedge sys_clk);
    uart_rx_in = 1'b0;
    idle(10);
    uart_rx_in = 1'b1;
    idle(2 * BIT_CYC);
    p = rand64();
    send_frame(p);
    idle(2 * BIT_CYC);
    checks++; if (got_q.size() !== 1 || got_q[0] !== p) begin errors++; $display("FAIL glitch_frame got %0d frames exp 1 frame %h", got_q.size(), p); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL glitch_err got %0d exp 0", err_cnt); end
  endtask

  task automatic test_framing();
    logic [63:0] p;
    clear_mon();
    p = rand64();
    send_byte(8'hAA, 1'b1);
    for (int i = 7; i >= 5; i--) send_byte(p[8*i +: 8], 1'b1);
    send_byte(p[39:32], 1'b0);
    idle(10 * BIT_CYC);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL ferr_err got %0d exp 1", err_cnt); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL ferr_count got %0d exp 0", got_q.size()); end
    send_byte(8'h55, 1'b1);
    send_byte(8'h00, 1'b1);
    p = rand64();
    send_frame(p);
    idle(2 * BIT_CYC);
    checks++; if (got_q.size() !== 1 || got_q[0] !== p) begin errors++; $display("FAIL junk_frame got %0d frames exp 1 frame %h", got_q.size(), p); end
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL junk_err got %0d exp 1", err_cnt); end
  endtask

  task automatic test_backpressure();
    logic [63:0] a;
    logic [63:0] b;
    set_ready(1'b0);
    clear_mon();
    a = rand64();
    b = rand64();
    send_frame(a);
    idle(20);
    checks++; if (rx_valid_out !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", rx_valid_out); end
    checks++; if ({rx_data1_out, rx_data2_out} !== a) begin errors++; $display("FAIL bp_data got %h exp %h", {rx_data1_out, rx_data2_out}, a); end
    send_frame(b);
    idle(20);
    checks++; if (ovr_cnt !== 1) begin errors++; $display("FAIL bp_overrun got %0d exp 1", ovr_cnt); end
    checks++; if (hold_changes !== 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", hold_changes); end
    checks++; if ({rx_data1_out, rx_data2_out} !== a) begin errors++; $display("FAIL bp_kept got %h exp %h", {rx_data1_out, rx_data2_out}, a); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL bp_err got %0d exp 0", err_cnt); end
    set_ready(1'b1);
    idle(3 * BIT_CYC);
    checks++; if (got_q.size() !== 1 || got_q[0] !== a) begin errors++; $display("FAIL bp_deliver got %0d frames exp 1 frame %h", got_q.size(), a); end
    checks++; if (rx_valid_out !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", rx_valid_out); end
  endtask

  task automatic test_timeout();
    int cyc;
    clear_mon();
    send_byte(8'hAA, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    cyc = 0;
    while (err_cnt == 0 && cyc < 2000) begin
      @(negedge sys_clk);
      cyc++;
    end
    checks++; if (cyc < 1200 || cyc > 1400) begin errors++; $display("FAIL timeout_delay got %0d cycles exp 1200..1400", cyc); end
    idle(BIT_CYC);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL timeout_err got %0d exp 1", err_cnt); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL timeout_count got %0d exp 0", got_q.size()); end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] p;
    set_ready(1'b0);
    clear_mon();
    send_frame(rand64());
    idle(20);
    send_byte(8'hAA, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    @(negedge sys_clk);
    uart_rx_in = 1'b0;
    idle(3 * BIT_CYC);
    #3 reset_n = 1'b0;
    #1;
    checks++; if (rx_valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", rx_valid_out); end
    checks++; if ({rx_data1_out, rx_data2_out} !== 64'h0) begin errors++; $display("FAIL midrst_data got %h exp 0", {rx_data1_out, rx_data2_out}); end
    uart_rx_in = 1'b1;
    idle(5);
    reset_n = 1'b1;
    set_ready(1'b1);
    idle(BIT_CYC);
    clear_mon();
    p = rand64();
    send_frame(p);
    idle(2 * BIT_CYC);
    checks++; if (got_q.size() !== 1 || got_q[0] !== p) begin errors++; $display("FAIL midrst_recover got %0d frames exp 1 frame %h", got_q.size(), p); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL midrst_err got %0d exp 0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_random_frames();
`ifdef UART_FRAME_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_glitch();
    test_framing();
    test_backpressure();
    test_timeout();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
